// File: rtl/ml_sched_pkg.sv
// Shared definitions for the accelerator command scheduler: op codes,
// FSM state encoding and command-queue entry sizing.
package ml_sched_pkg;

  typedef enum logic [1:0] {
    OP_CONV2D   = 2'b00,
    OP_DWCONV2D = 2'b01,
    OP_MATADD   = 2'b10,
    OP_FC       = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  localparam int OP_W   = 2;
  localparam int DATA_W = 32;

  // Entry layout, MSB first: {op, rs1, rs2, tag}
  localparam int CMD_PAYLOAD_W = OP_W + 2 * DATA_W;

  function automatic int cmd_entry_w(input int tag_w);
    return CMD_PAYLOAD_W + tag_w;
  endfunction

endpackage

// File: rtl/ml_cmd_fifo.sv
// Synchronous FIFO for scheduler commands; head word is visible on rdata
// whenever the FIFO is non-empty and is consumed by pop.
module ml_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_reg == FULL_LEVEL);
  assign empty   = (level_reg == '0);
  assign level   = level_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_reg];

  // Storage carries no reset so it maps onto distributed/block memory.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/ml_accel_scheduler.sv
// Queues CPU commands and sequences the accelerator one command at a time,
// returning each result (or a watchdog timeout) on a tagged response port.
module ml_accel_scheduler #(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TAG_W          = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [31:0]                  cmd_rs1,
  input  logic [31:0]                  cmd_rs2,
  input  logic [TAG_W-1:0]             cmd_tag,
  output logic                         accel_start,
  output logic [1:0]                   accel_op_mode,
  output logic [31:0]                  accel_rs1_data,
  output logic [31:0]                  accel_rs2_data,
  input  logic                         accel_ready,
  input  logic                         accel_done,
  input  logic [31:0]                  accel_result,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [31:0]                  rsp_data,
  output logic [TAG_W-1:0]             rsp_tag,
  output logic                         rsp_err,
  output logic                         busy,
  output logic [$clog2(CMD_DEPTH):0]   queue_level
);

  import ml_sched_pkg::*;

  localparam int ENTRY_W = cmd_entry_w(TAG_W);
  localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e              state_reg, state_next;
  logic [CNT_W-1:0]    wd_cnt_reg;
  logic [OP_W-1:0]     op_reg;
  logic [DATA_W-1:0]   rs1_reg, rs2_reg;
  logic [TAG_W-1:0]    tag_reg;
  logic [DATA_W-1:0]   rsp_data_reg;
  logic [TAG_W-1:0]    rsp_tag_reg;
  logic                rsp_err_reg;

  logic                fifo_full, fifo_empty, fifo_pop;
  logic [ENTRY_W-1:0]  fifo_rdata;
  logic [OP_W-1:0]     head_op;
  logic [DATA_W-1:0]   head_rs1, head_rs2;
  logic [TAG_W-1:0]    head_tag;
  logic                rsp_load, rsp_timeout;

  ml_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .wdata ({cmd_op, cmd_rs1, cmd_rs2, cmd_tag}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (queue_level)
  );

  assign {head_op, head_rs1, head_rs2, head_tag} = fifo_rdata;

  always_comb begin
    state_next  = state_reg;
    fifo_pop    = 1'b0;
    accel_start = 1'b0;
    rsp_valid   = 1'b0;
    rsp_load    = 1'b0;
    rsp_timeout = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty && accel_ready) begin
          fifo_pop   = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        accel_start = 1'b1;
        state_next  = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the limit cycle still counts as a real result.
        if (accel_done) begin
          rsp_load   = 1'b1;
          state_next = ST_RESP;
        end else if (wd_cnt_reg == WD_LIMIT) begin
          rsp_load    = 1'b1;
          rsp_timeout = 1'b1;
          state_next  = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      wd_cnt_reg   <= '0;
      op_reg       <= '0;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      tag_reg      <= '0;
      rsp_data_reg <= '0;
      rsp_tag_reg  <= '0;
      rsp_err_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_WAIT) wd_cnt_reg <= wd_cnt_reg + 1'b1;
      else                      wd_cnt_reg <= '0;
      if (fifo_pop) begin
        op_reg  <= head_op;
        rs1_reg <= head_rs1;
        rs2_reg <= head_rs2;
        tag_reg <= head_tag;
      end
      if (rsp_load) begin
        rsp_data_reg <= rsp_timeout ? '0 : accel_result;
        rsp_tag_reg  <= tag_reg;
        rsp_err_reg  <= rsp_timeout;
      end
    end
  end

  assign cmd_ready      = !fifo_full;
  assign busy           = (state_reg != ST_IDLE) || !fifo_empty;
  assign accel_op_mode  = op_reg;
  assign accel_rs1_data = rs1_reg;
  assign accel_rs2_data = rs2_reg;
  assign rsp_data       = rsp_data_reg;
  assign rsp_tag        = rsp_tag_reg;
  assign rsp_err        = rsp_err_reg;

endmodule

// File: tb/tb_ml_accel_scheduler.sv
// Scoreboard bench for ml_accel_scheduler: directed commands push expected
// responses; a negedge monitor pops and compares on every response handshake.
module tb_ml_accel_scheduler;

  localparam int CMD_DEPTH      = 4;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int TAG_W          = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid, cmd_ready;
  logic [1:0]        cmd_op;
  logic [31:0]       cmd_rs1, cmd_rs2;
  logic [TAG_W-1:0]  cmd_tag;
  logic              accel_start;
  logic [1:0]        accel_op_mode;
  logic [31:0]       accel_rs1_data, accel_rs2_data;
  logic              accel_ready, accel_done;
  logic [31:0]       accel_result;
  logic              rsp_valid, rsp_ready;
  logic [31:0]       rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_err, busy;
  logic [2:0]        queue_level;

  always #5 clk = ~clk;

  ml_accel_scheduler #(
    .CMD_DEPTH(CMD_DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_tag(cmd_tag),
    .accel_start(accel_start), .accel_op_mode(accel_op_mode),
    .accel_rs1_data(accel_rs1_data), .accel_rs2_data(accel_rs2_data),
    .accel_ready(accel_ready), .accel_done(accel_done), .accel_result(accel_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy), .queue_level(queue_level)
  );

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } rsp_t;

  rsp_t sb[$];
  rsp_t exp_r;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   start_cnt = 0;
  int   last_start_cyc = 0;
  int   last_rise_cyc = 0;
  logic prev_valid = 1'b0;

  // Queue-fill vectors and hand-computed sums (accelerator stand-in adds).
  logic [31:0] va [5] = '{32'h10, 32'h2000, 32'hFFFF_FFFF, 32'h1234, 32'hA0};
  logic [31:0] vb [5] = '{32'h01, 32'h0300, 32'h0000_0002, 32'h4321, 32'h0B};
  logic [31:0] ve [5] = '{32'h11, 32'h2300, 32'h0000_0001, 32'h5555, 32'hAB};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: start/response bookkeeping and scoreboard comparison.
  always @(negedge clk) begin
    if (accel_start) begin
      start_cnt++;
      last_start_cyc = cyc;
    end
    if (rsp_valid && !prev_valid) last_rise_cyc = cyc;
    prev_valid = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_rsp: got tag %0d data 0x%08h, expected no response", rsp_tag, rsp_data);
      end else begin
        exp_r = sb.pop_front();
        $display("rsp tag=%0d data=0x%08h err=%0d", rsp_tag, rsp_data, rsp_err);
        check("rsp_data", rsp_data, exp_r.data);
        check("rsp_tag", 32'(rsp_tag), 32'(exp_r.tag));
        check("rsp_err", 32'(rsp_err), 32'(exp_r.err));
      end
    end
  end

  // Accelerator model: done (result = rs1 + rs2) model_lat negedges after start.
  int model_lat = 3;
  bit done_en = 1'b1;
  int cd = 0;
  initial begin
    accel_done = 1'b0;
    accel_result = '0;
    forever begin
      @(negedge clk);
      accel_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0 && done_en) begin
          accel_done = 1'b1;
          accel_result = accel_rs1_data + accel_rs2_data;
        end
      end
      if (accel_start) cd = model_lat;
    end
  end

  task automatic expect_rsp(input logic [31:0] d, input logic [TAG_W-1:0] t, input logic e);
    rsp_t r;
    r.data = d; r.tag = t; r.err = e;
    sb.push_back(r);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag);
    bit ok = 1'b0;
    cmd_op = op; cmd_rs1 = a; cmd_rs2 = b; cmd_tag = tag; cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    $display("push op=%0d rs1=0x%08h rs2=0x%08h tag=%0d accepted=%0d", op, a, b, tag, ok);
    if (!ok) begin
      total_cnt++;
      $display("FAIL push_timeout: tag %0d got not accepted, expected accepted", tag);
    end
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    bit drained = 1'b0;
    for (int i = 0; i < max_cycles && !drained; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) drained = 1'b1;
    end
    check(name, 32'(drained), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({pfx, "_start"}, 32'(accel_start), 32'd0);
    check({pfx, "_op"}, 32'(accel_op_mode), 32'd0);
    check({pfx, "_rs1"}, accel_rs1_data, 32'd0);
    check({pfx, "_rs2"}, accel_rs2_data, 32'd0);
    check({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({pfx, "_rsp_data"}, rsp_data, 32'd0);
    check({pfx, "_rsp_tag"}, 32'(rsp_tag), 32'd0);
    check({pfx, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
    check({pfx, "_level"}, 32'(queue_level), 32'd0);
  endtask

  initial begin
    int s0;
    bit bad;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_tag = '0;
    accel_ready = 1'b1; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Single command: start exactly one cycle after acceptance, then response.
    model_lat = 8;
    s0 = start_cnt;
    expect_rsp(32'h0000_000C, 4'd3, 1'b0);
    push(2'b10, 32'h5, 32'h7, 4'd3);
    @(negedge clk); check("t1_no_early_start", 32'(accel_start), 32'd0);
    @(negedge clk); check("t1_start", 32'(accel_start), 32'd1);
    check("t1_op", 32'(accel_op_mode), 32'd2);
    check("t1_rs1", accel_rs1_data, 32'h5);
    check("t1_rs2", accel_rs2_data, 32'h7);
    @(negedge clk); check("t1_start_one_cycle", 32'(accel_start), 32'd0);
    wait_drain("t1_drain", 100);
    check("t1_start_count", 32'(start_cnt - s0), 32'd1);
    check("t1_done_to_rsp", 32'(last_rise_cyc - last_start_cyc), 32'd9);

    // Queue fill with the accelerator held busy.
    accel_ready = 1'b0;
    model_lat = 3;
    for (int t = 0; t < 4; t++) begin
      expect_rsp(ve[t], 4'(t), 1'b0);
      push(2'(t), va[t], vb[t], 4'(t));
    end
    @(negedge clk);
    check("t2_full_ready", 32'(cmd_ready), 32'd0);
    check("t2_full_level", 32'(queue_level), 32'd4);
    check("t2_busy", 32'(busy), 32'd1);
    cmd_op = 2'b01; cmd_rs1 = va[4]; cmd_rs2 = vb[4]; cmd_tag = 4'd4; cmd_valid = 1'b1;
    expect_rsp(ve[4], 4'd4, 1'b0);
    @(negedge clk); check("t2_full_hold", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1 accel_ready = 1'b1;
    @(negedge clk);
    check("t2_no_bypass", 32'(cmd_ready), 32'd0);
    check("t2_level_before_pop", 32'(queue_level), 32'd4);
    @(negedge clk);
    check("t2_level_after_pop", 32'(queue_level), 32'd3);
    check("t2_ready_after_pop", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk); check("t2_level_fifth", 32'(queue_level), 32'd4);
    wait_drain("t2_drain", 400);

    // Watchdog timeout, then a normal command still issues.
    done_en = 1'b0;
    expect_rsp(32'h0, 4'd5, 1'b1);
    push(2'b01, 32'h11, 32'h22, 4'd5);
    wait_drain("t3_drain", 100);
    check("t3_timeout_latency", 32'(last_rise_cyc - last_start_cyc), 32'd17);
    done_en = 1'b1;
    s0 = start_cnt;
    expect_rsp(32'h33, 4'd6, 1'b0);
    push(2'b00, 32'h11, 32'h22, 4'd6);
    wait_drain("t3_next_drain", 100);
    check("t3_next_started", 32'(start_cnt - s0), 32'd1);

    // Response backpressure with a second command waiting.
    rsp_ready = 1'b0;
    model_lat = 2;
    expect_rsp(32'h30, 4'd7, 1'b0);
    expect_rsp(32'h44, 4'd8, 1'b0);
    push(2'b11, 32'h10, 32'h20, 4'd7);
    push(2'b11, 32'h40, 32'h04, 4'd8);
    bad = 1'b1;
    for (int i = 0; i < 100 && bad; i++) begin
      @(negedge clk);
      if (rsp_valid) bad = 1'b0;
    end
    check("t4_rsp_seen", 32'(bad), 32'd0);
    #1 s0 = start_cnt;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== 32'h30 || rsp_tag !== 4'd7 || rsp_err !== 1'b0) bad = 1'b1;
    end
    #1;
    check("t4_rsp_stable", 32'(bad), 32'd0);
    check("t4_no_start", 32'(start_cnt - s0), 32'd0);
    check("t4_level", 32'(queue_level), 32'd1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_drain("t4_drain", 100);

    // done on the same cycle the watchdog hits its limit.
    model_lat = 16;
    expect_rsp(32'h123, 4'd9, 1'b0);
    push(2'b10, 32'h100, 32'h23, 4'd9);
    wait_drain("t5_drain", 100);
    check("t5_collision_latency", 32'(last_rise_cyc - last_start_cyc), 32'd17);

    // Reset while waiting with two commands queued.
    done_en = 1'b0;
    model_lat = 3;
    push(2'b11, 32'h1, 32'h1, 4'd10);
    push(2'b11, 32'h2, 32'h2, 4'd11);
    push(2'b11, 32'h3, 32'h3, 4'd12);
    repeat (4) @(negedge clk);
    check("t6_level_pre", 32'(queue_level), 32'd2);
    check("t6_op_pre", 32'(accel_op_mode), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    s0 = start_cnt;
    cd = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    done_en = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("t6_no_start", 32'(start_cnt - s0), 32'd0);
    check("t6_level_post", 32'(queue_level), 32'd0);
    check("t6_busy_post", 32'(busy), 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
